dual_cam_rd_sched: RTL and testbench

- Schedules burst reads from one shared SDRAM read port into two per-camera display line FIFOs (cam0 = left half, cam1 = right half of the LCD).
- Generates per-camera read addresses and arbitrates between the two FIFOs by fill level.
- Truncates the last burst of each frame and restarts both address streams at frame start.
- Sits between the SDRAM controller read port and the FIFOs that feed rd_data to the LCD pixel path.

---
 rtl/dual_cam_rd_sched.sv | 172 +++++++++++++++++
 tb/tb_dual_cam_rd_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_cam_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : dual_cam_rd_sched
// Description : Burst read scheduler feeding two per-camera LCD line FIFOs
//               (cam0 = left half, cam1 = right half) from one shared SDRAM
//               read port. Generates per-camera addresses, arbitrates by FIFO
//               fill level, truncates the final burst of each frame and
//               restarts both address streams on frame_start.
// Optional    : `define DUAL_SCHED_PRIO_EN -> when both FIFOs are eligible
//               the emptier one wins; ties fall back to round-robin.
// Ports       : lcd_clk, sys_rst (async, active high)
//               frame_start         vsync pulse, requests a frame restart
//               rd_h_pixel/v_pixel  camera resolution (full width)
//               fifo0/1_used        FIFO fill levels
//               fifo_clr            one-cycle clear to both FIFOs
//               rd_req/addr/len/sel burst request to SDRAM controller
//               rd_ack, rd_done     controller accept / burst complete
// Revision    : 1.0 - initial release
// ============================================================================
module dual_cam_rd_sched #(
   parameter int                ADDR_W    = 24,
   parameter int                BURST_LEN = 64,
   parameter int                FIFO_AW   = 10,
   parameter int                THRESH    = 512,
   parameter logic [ADDR_W-1:0] BASE0     = 24'h000000,
   parameter logic [ADDR_W-1:0] BASE1     = 24'h200000
) (
   input  logic               lcd_clk,
   input  logic               sys_rst,
   input  logic               frame_start,
   input  logic [12:0]        rd_h_pixel,
   input  logic [12:0]        rd_v_pixel,
   input  logic [FIFO_AW-1:0] fifo0_used,
   input  logic [FIFO_AW-1:0] fifo1_used,
   output logic               fifo_clr,
   output logic               rd_req,
   output logic [ADDR_W-1:0]  rd_addr,
   output logic [6:0]         rd_len,
   output logic               rd_sel,
   input  logic               rd_ack,
   input  logic               rd_done
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ARB       = 3'd1,
      S_REQ       = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_RESTART   = 3'd4
   } state_t;

   // One extra bit so THRESH equal to the FIFO depth is still representable.
   localparam logic [FIFO_AW:0] c_thresh = (FIFO_AW+1)'(THRESH);
   localparam logic [25:0]      c_burst  = 26'(BURST_LEN);

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr0;
   logic [ADDR_W-1:0] r_addr1;
   logic [25:0]       r_rem0;
   logic [25:0]       r_rem1;
   logic              r_rr_last;
   logic              r_pend_frame;

   logic [12:0]       w_h_half;
   logic [25:0]       w_cam_words;
   logic              w_elig0;
   logic              w_elig1;
   logic              w_pick;
   logic [25:0]       w_rem_pick;
   logic [6:0]        w_len;

   // Each camera covers half the LCD width, hence the halved h resolution.
   assign w_h_half    = rd_h_pixel >> 1;
   assign w_cam_words = 26'(w_h_half) * 26'(rd_v_pixel);

   assign w_elig0 = ({1'b0, fifo0_used} < c_thresh) && (r_rem0 != 26'd0);
   assign w_elig1 = ({1'b0, fifo1_used} < c_thresh) && (r_rem1 != 26'd0);

   always_comb begin
      w_pick = 1'b0;
      if (w_elig0 && w_elig1) begin
`ifdef DUAL_SCHED_PRIO_EN
         if (fifo0_used < fifo1_used)
            w_pick = 1'b0;
         else if (fifo1_used < fifo0_used)
            w_pick = 1'b1;
         else
            w_pick = ~r_rr_last;
`else
         w_pick = ~r_rr_last;
`endif
      end else begin
         // Single eligible FIFO; ARB is only entered when one exists.
         w_pick = w_elig1;
      end
   end

   // Final burst of a frame is truncated to whatever words remain.
   assign w_rem_pick = w_pick ? r_rem1 : r_rem0;
   assign w_len      = (w_rem_pick < c_burst) ? w_rem_pick[6:0] : 7'(BURST_LEN);

   always_ff @(posedge lcd_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state      <= S_IDLE;
         r_addr0      <= BASE0;
         r_addr1      <= BASE1;
         r_rem0       <= 26'd0;
         r_rem1       <= 26'd0;
         r_rr_last    <= 1'b1;
         r_pend_frame <= 1'b0;
         fifo_clr     <= 1'b0;
         rd_req       <= 1'b0;
         rd_addr      <= '0;
         rd_len       <= 7'd0;
         rd_sel       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Restart only from IDLE so the FIFO clear never hits a burst
               // that is still being written.
               if (r_pend_frame) begin
                  r_state  <= S_RESTART;
                  fifo_clr <= 1'b1;
               end else if (w_elig0 || w_elig1) begin
                  r_state <= S_ARB;
               end
            end
            S_RESTART: begin
               fifo_clr     <= 1'b0;
               r_addr0      <= BASE0;
               r_addr1      <= BASE1;
               r_rem0       <= w_cam_words;
               r_rem1       <= w_cam_words;
               r_pend_frame <= 1'b0;
               r_state      <= S_IDLE;
            end
            S_ARB: begin
               rd_sel  <= w_pick;
               rd_addr <= w_pick ? r_addr1 : r_addr0;
               rd_len  <= w_len;
               rd_req  <= 1'b1;
               r_state <= S_REQ;
            end
            S_REQ: begin
               if (rd_ack) begin
                  rd_req    <= 1'b0;
                  r_rr_last <= rd_sel;
                  if (rd_sel) begin
                     r_addr1 <= r_addr1 + ADDR_W'(rd_len);
                     r_rem1  <= r_rem1 - 26'(rd_len);
                  end else begin
                     r_addr0 <= r_addr0 + ADDR_W'(rd_len);
                     r_rem0  <= r_rem0 - 26'(rd_len);
                  end
                  r_state <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (rd_done)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         // A vsync arriving in any state (even RESTART) is never lost.
         if (frame_start)
            r_pend_frame <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dual_cam_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_cam_rd_sched
// Description : Directed self-checking bench for dual_cam_rd_sched. Inputs
//               are driven and outputs sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_cam_rd_sched;

   logic        lcd_clk = 1'b0;
   logic        sys_rst;
   logic        frame_start;
   logic [12:0] rd_h_pixel;
   logic [12:0] rd_v_pixel;
   logic [9:0]  fifo0_used;
   logic [9:0]  fifo1_used;
   logic        fifo_clr;
   logic        rd_req;
   logic [23:0] rd_addr;
   logic [6:0]  rd_len;
   logic        rd_sel;
   logic        rd_ack;
   logic        rd_done;

   int checks = 0;
   int errors = 0;

   always #5 lcd_clk = ~lcd_clk;

   dual_cam_rd_sched dut (
      .lcd_clk     (lcd_clk),
      .sys_rst     (sys_rst),
      .frame_start (frame_start),
      .rd_h_pixel  (rd_h_pixel),
      .rd_v_pixel  (rd_v_pixel),
      .fifo0_used  (fifo0_used),
      .fifo1_used  (fifo1_used),
      .fifo_clr    (fifo_clr),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .rd_len      (rd_len),
      .rd_sel      (rd_sel),
      .rd_ack      (rd_ack),
      .rd_done     (rd_done)
   );

   // ---------------- stimulus helpers (no checking inside) ----------------
   task automatic wait_req(input int max_cycles, output bit got);
      got = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         if (rd_req === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge lcd_clk);
      end
   endtask

   task automatic wait_clr(input int max_cycles, output bit got);
      got = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         if (fifo_clr === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge lcd_clk);
      end
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      @(negedge lcd_clk);
      frame_start = 1'b0;
   endtask

   // Accept the pending request and complete the burst. With park set, both
   // FIFOs are reported full when the burst finishes so the DUT stays idle.
   task automatic ack_and_done(input bit park);
      rd_ack = 1'b1;
      @(negedge lcd_clk);
      rd_ack = 1'b0;
      @(negedge lcd_clk);
      rd_done = 1'b1;
      if (park) begin
         fifo0_used = 10'd1000;
         fifo1_used = 10'd1000;
      end
      @(negedge lcd_clk);
      rd_done = 1'b0;
   endtask

   // ------------------------------ tests ----------------------------------
   task automatic test_reset();
      sys_rst = 1'b1;
      frame_start = 1'b0; rd_ack = 1'b0; rd_done = 1'b0;
      rd_h_pixel = 13'd0; rd_v_pixel = 13'd0;
      fifo0_used = 10'd0; fifo1_used = 10'd0;
      repeat (3) @(negedge lcd_clk);
      checks++; if (fifo_clr !== 1'b0) begin errors++; $display("FAIL reset_fifo_clr: got %b expected 0", fifo_clr); end
      checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b expected 0", rd_req); end
      checks++; if (rd_addr !== 24'h0) begin errors++; $display("FAIL reset_rd_addr: got %h expected 000000", rd_addr); end
      checks++; if (rd_len !== 7'd0) begin errors++; $display("FAIL reset_rd_len: got %0d expected 0", rd_len); end
      checks++; if (rd_sel !== 1'b0) begin errors++; $display("FAIL reset_rd_sel: got %b expected 0", rd_sel); end
      sys_rst = 1'b0;
      repeat (6) @(negedge lcd_clk);
      // Remaining counts are zero after reset: nothing may be requested.
      checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got rd_req %b expected 0", rd_req); end
   endtask

   task automatic test_full_frame();
      logic        exp_sel  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [23:0] exp_addr [4] = '{24'h000000, 24'h200000, 24'h000040, 24'h200040};
      bit got;
      rd_h_pixel = 13'd1280; rd_v_pixel = 13'd720;
      fifo0_used = 10'd0; fifo1_used = 10'd0;
      pulse_frame();
      wait_clr(10, got);
      checks++; if (!got) begin errors++; $display("FAIL full_fifo_clr: got none expected pulse"); end
      for (int k = 0; k < 4; k++) begin
         wait_req(20, got);
         checks++; if (!got) begin errors++; $display("FAIL full_req[%0d]: got timeout expected rd_req", k); end
         checks++; if (rd_sel !== exp_sel[k]) begin errors++; $display("FAIL full_sel[%0d]: got %b expected %b", k, rd_sel, exp_sel[k]); end
         checks++; if (rd_addr !== exp_addr[k]) begin errors++; $display("FAIL full_addr[%0d]: got %h expected %h", k, rd_addr, exp_addr[k]); end
         checks++; if (rd_len !== 7'd64) begin errors++; $display("FAIL full_len[%0d]: got %0d expected 64", k, rd_len); end
         ack_and_done(k == 3);
      end
   endtask

   task automatic test_short_frame();
      logic        exp_sel  [2] = '{1'b0, 1'b1};
      logic [23:0] exp_addr [2] = '{24'h000000, 24'h200000};
      bit got;
      int extra;
      rd_h_pixel = 13'd100; rd_v_pixel = 13'd1;
      pulse_frame();
      wait_clr(10, got);
      checks++; if (!got) begin errors++; $display("FAIL short_fifo_clr: got none expected pulse"); end
      fifo0_used = 10'd0; fifo1_used = 10'd0;
      for (int k = 0; k < 2; k++) begin
         wait_req(20, got);
         checks++; if (!got) begin errors++; $display("FAIL short_req[%0d]: got timeout expected rd_req", k); end
         checks++; if (rd_sel !== exp_sel[k]) begin errors++; $display("FAIL short_sel[%0d]: got %b expected %b", k, rd_sel, exp_sel[k]); end
         checks++; if (rd_addr !== exp_addr[k]) begin errors++; $display("FAIL short_addr[%0d]: got %h expected %h", k, rd_addr, exp_addr[k]); end
         checks++; if (rd_len !== 7'd50) begin errors++; $display("FAIL short_len[%0d]: got %0d expected 50", k, rd_len); end
         ack_and_done(1'b0);
      end
      extra = 0;
      for (int i = 0; i < 30; i++) begin
         if (rd_req === 1'b1) extra++;
         @(negedge lcd_clk);
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL short_no_more_req: got %0d req cycles expected 0", extra); end
   endtask

   task automatic test_threshold();
      logic        exp_sel  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [23:0] exp_addr [4] = '{24'h200000, 24'h200040, 24'h200080, 24'h000000};
      bit got;
      rd_h_pixel = 13'd1280; rd_v_pixel = 13'd720;
      pulse_frame();
      wait_clr(10, got);
      checks++; if (!got) begin errors++; $display("FAIL thr_fifo_clr: got none expected pulse"); end
      fifo0_used = 10'd600; fifo1_used = 10'd100;
      for (int k = 0; k < 4; k++) begin
         wait_req(20, got);
         checks++; if (!got) begin errors++; $display("FAIL thr_req[%0d]: got timeout expected rd_req", k); end
         checks++; if (rd_sel !== exp_sel[k]) begin errors++; $display("FAIL thr_sel[%0d]: got %b expected %b", k, rd_sel, exp_sel[k]); end
         checks++; if (rd_addr !== exp_addr[k]) begin errors++; $display("FAIL thr_addr[%0d]: got %h expected %h", k, rd_addr, exp_addr[k]); end
         ack_and_done(k == 3);
         // cam0 drains below threshold after three cam1-only bursts
         if (k == 2) fifo0_used = 10'd100;
      end
   endtask

   task automatic test_frame_mid_burst();
      bit got;
      fifo0_used = 10'd0; fifo1_used = 10'd0;
      wait_req(20, got);
      checks++; if (!got) begin errors++; $display("FAIL mid_req: got timeout expected rd_req"); end
      checks++; if (rd_addr !== 24'h2000C0) begin errors++; $display("FAIL mid_addr: got %h expected 2000c0", rd_addr); end
      rd_ack = 1'b1;
      @(negedge lcd_clk);
      rd_ack = 1'b0;
      pulse_frame();
      for (int i = 0; i < 5; i++) begin
         checks++; if (fifo_clr !== 1'b0) begin errors++; $display("FAIL mid_clr_early[%0d]: got %b expected 0", i, fifo_clr); end
         @(negedge lcd_clk);
      end
      rd_done = 1'b1;
      @(negedge lcd_clk);
      rd_done = 1'b0;
      wait_clr(10, got);
      checks++; if (!got) begin errors++; $display("FAIL mid_fifo_clr: got none expected pulse"); end
      wait_req(20, got);
      checks++; if (!got) begin errors++; $display("FAIL mid_req0: got timeout expected rd_req"); end
      checks++; if (rd_sel !== 1'b0 || rd_addr !== 24'h000000) begin errors++; $display("FAIL mid_restart0: got sel %b addr %h expected sel 0 addr 000000", rd_sel, rd_addr); end
      ack_and_done(1'b0);
      wait_req(20, got);
      checks++; if (!got) begin errors++; $display("FAIL mid_req1: got timeout expected rd_req"); end
      checks++; if (rd_sel !== 1'b1 || rd_addr !== 24'h200000) begin errors++; $display("FAIL mid_restart1: got sel %b addr %h expected sel 1 addr 200000", rd_sel, rd_addr); end
      // request left pending for the stall test
   endtask

   task automatic test_ack_stall();
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (rd_req !== 1'b1 || rd_sel !== 1'b1 || rd_addr !== 24'h200000 || rd_len !== 7'd64) begin
            errors++;
            $display("FAIL stall[%0d]: got req %b sel %b addr %h len %0d expected req 1 sel 1 addr 200000 len 64",
                     i, rd_req, rd_sel, rd_addr, rd_len);
         end
         @(negedge lcd_clk);
      end
      ack_and_done(1'b1);
   endtask

   // rr_last is 1 here, so plain round-robin gives cam0 while priority
   // gives the emptier cam1.
   task automatic test_arb_both_eligible();
      bit got;
      logic        exp_sel;
      logic [23:0] exp_addr;
`ifdef DUAL_SCHED_PRIO_EN
      exp_sel = 1'b1; exp_addr = 24'h200040;
`else
      exp_sel = 1'b0; exp_addr = 24'h000040;
`endif
      fifo0_used = 10'd300; fifo1_used = 10'd100;
      wait_req(20, got);
      checks++; if (!got) begin errors++; $display("FAIL arb_req: got timeout expected rd_req"); end
      checks++; if (rd_sel !== exp_sel) begin errors++; $display("FAIL arb_sel: got %b expected %b", rd_sel, exp_sel); end
      checks++; if (rd_addr !== exp_addr) begin errors++; $display("FAIL arb_addr: got %h expected %h", rd_addr, exp_addr); end
      ack_and_done(1'b1);
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_short_frame();
      test_threshold();
      test_frame_mid_burst();
      test_ack_stall();
      test_arb_both_eligible();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
